painterengine_gpu_render_scheduler: RTL and testbench

//  Command queue and sequencer for painterengine_gpu_renderer. Host logic pushes blit jobs (addresses, widths, extents).
//  The block runs them one at a time: it loads the renderer config, releases its reset, and watches its state word.
//  It retires each job on DONE and reports completion, error and timeout status.

---
 rtl/painterengine_gpu_render_scheduler_pkg.sv | 32 +++
 rtl/painterengine_gpu_cmd_fifo.sv | 57 +++++
 rtl/painterengine_gpu_render_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_painterengine_gpu_render_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/painterengine_gpu_render_scheduler_pkg.sv
// Shared definitions for the render scheduler: renderer state codes,
// scheduler state encoding and the packed job word.
package painterengine_gpu_render_scheduler_pkg;

  // Renderer state word codes, low byte only
  localparam logic [7:0] RSTATE_DONE  = 8'h05;
  localparam logic [7:0] RSTATE_ERROR = 8'h06;

  // Six 32-bit fields per job
  localparam int JOB_W = 192;

  // Scheduler states; the encoding is visible on o_wire_state
  typedef enum logic [7:0] {
    ST_IDLE   = 8'h00,
    ST_LOAD   = 8'h01,
    ST_START  = 8'h02,
    ST_RUN    = 8'h03,
    ST_RETIRE = 8'h04,
    ST_ERROR  = 8'h05
  } sched_state_t;

  // Job word, fields in port order with the source address in the top bits
  typedef struct packed {
    logic [31:0] src_address;
    logic [31:0] dst_address;
    logic [31:0] src_width;
    logic [31:0] dst_width;
    logic [31:0] xcount;
    logic [31:0] ycount;
  } job_t;

endpackage

// File: rtl/painterengine_gpu_cmd_fifo.sv
// Synchronous job FIFO with occupancy level and a synchronous flush.
// A push while full or a pop while empty is ignored.
module painterengine_gpu_cmd_fifo #(
  parameter int WIDTH = 192,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage array; stale entries are harmless because pointers gate reads
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers and level; flush wins over a simultaneous push or pop
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (w_pop && !w_push) r_level <= r_level - 1'b1;
    end
  end

endmodule

// File: rtl/painterengine_gpu_render_scheduler.sv
// Render job scheduler: queues blit jobs and runs them one at a time on the
// renderer, holding its config stable while it is out of reset.
// Handshake: a job is accepted on a clock edge where i_wire_cmd_valid and
// o_wire_cmd_ready are both high; the host holds valid and data until then.
module painterengine_gpu_render_scheduler
  import painterengine_gpu_render_scheduler_pkg::*;
#(
  parameter int          QUEUE_DEPTH    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 32'd16777216
) (
  input  logic        i_wire_clock,
  input  logic        i_wire_resetn,
  input  logic        i_wire_cmd_valid,
  output logic        o_wire_cmd_ready,
  input  logic [31:0] i_wire_cmd_src_address,
  input  logic [31:0] i_wire_cmd_dst_address,
  input  logic [31:0] i_wire_cmd_src_width,
  input  logic [31:0] i_wire_cmd_dst_width,
  input  logic [31:0] i_wire_cmd_xcount,
  input  logic [31:0] i_wire_cmd_ycount,
  input  logic        i_wire_error_clear,
  output logic        o_wire_renderer_resetn,
  output logic [31:0] o_wire_src_frame_buffer_address,
  output logic [31:0] o_wire_dst_frame_buffer_address,
  output logic [31:0] o_wire_src_frame_buffer_width,
  output logic [31:0] o_wire_dst_frame_buffer_width,
  output logic [31:0] o_wire_render_frame_buffer_xcount,
  output logic [31:0] o_wire_render_frame_buffer_ycount,
  input  logic [31:0] i_wire_renderer_state,
  output logic        o_wire_done_pulse,
  output logic        o_wire_error,
  output logic        o_wire_timeout,
  output logic        o_wire_busy,
  output logic [7:0]  o_wire_queue_level,
  output logic [31:0] o_wire_completed_count,
  output logic [31:0] o_wire_state
);

  localparam int LAW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

  sched_state_t r_state;
  job_t         r_cfg;
  logic         r_ready_en;
  logic         r_rend_rstn;
  logic         r_done;
  logic         r_error;
  logic         r_timeout;
  logic [31:0]  r_count;
  logic [31:0]  r_timer;

  job_t         w_job_in;
  job_t         w_head;
  logic         w_push;
  logic         w_pop;
  logic         w_flush;
  logic         w_full;
  logic         w_empty;
  logic [LAW:0] w_level;
  logic         w_timeout_hit;
  logic         w_unused_state_hi;

  assign w_job_in = '{src_address: i_wire_cmd_src_address,
                      dst_address: i_wire_cmd_dst_address,
                      src_width:   i_wire_cmd_src_width,
                      dst_width:   i_wire_cmd_dst_width,
                      xcount:      i_wire_cmd_xcount,
                      ycount:      i_wire_cmd_ycount};

  assign o_wire_cmd_ready = r_ready_en && !w_full;
  assign w_push  = i_wire_cmd_valid && o_wire_cmd_ready;
  assign w_pop   = (r_state == ST_LOAD);
  assign w_flush = (r_state == ST_ERROR) && i_wire_error_clear;

  // A zero limit disables the timeout entirely
  assign w_timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         (r_timer == 32'(TIMEOUT_CYCLES - 1));

  // Only the low byte of the renderer state word carries a code
  assign w_unused_state_hi = ^i_wire_renderer_state[31:8];

  painterengine_gpu_cmd_fifo #(
    .WIDTH (JOB_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_cmd_fifo (
    .i_clk   (i_wire_clock),
    .i_rst_n (i_wire_resetn),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_data  (w_job_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign o_wire_renderer_resetn            = r_rend_rstn;
  assign o_wire_src_frame_buffer_address   = r_cfg.src_address;
  assign o_wire_dst_frame_buffer_address   = r_cfg.dst_address;
  assign o_wire_src_frame_buffer_width     = r_cfg.src_width;
  assign o_wire_dst_frame_buffer_width     = r_cfg.dst_width;
  assign o_wire_render_frame_buffer_xcount = r_cfg.xcount;
  assign o_wire_render_frame_buffer_ycount = r_cfg.ycount;
  assign o_wire_done_pulse                 = r_done;
  assign o_wire_error                      = r_error;
  assign o_wire_timeout                    = r_timeout;
  assign o_wire_busy                       = (r_state != ST_IDLE) || !w_empty;
  assign o_wire_queue_level                = 8'(w_level);
  assign o_wire_completed_count            = r_count;
  assign o_wire_state                      = {24'd0, r_state};

  // Scheduler FSM; status outputs are registered and line up with the state
  // they describe (done/count during RETIRE, error/timeout during ERROR)
  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      r_state     <= ST_IDLE;
      r_cfg       <= '0;
      r_ready_en  <= 1'b0;
      r_rend_rstn <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_timeout   <= 1'b0;
      r_count     <= '0;
      r_timer     <= '0;
    end else begin
      r_ready_en <= 1'b1;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_rend_rstn <= 1'b0;
          if (!w_empty) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_cfg <= w_head;
          if (w_head.xcount == 32'd0 || w_head.ycount == 32'd0) begin
            r_done  <= 1'b1;
            r_count <= r_count + 32'd1;
            r_state <= ST_RETIRE;
          end else begin
            r_state <= ST_START;
          end
        end
        ST_START: begin
          r_rend_rstn <= 1'b1;
          r_timer     <= '0;
          r_state     <= ST_RUN;
        end
        ST_RUN: begin
          if (i_wire_renderer_state[7:0] == RSTATE_ERROR) begin
            r_rend_rstn <= 1'b0;
            r_error     <= 1'b1;
            r_state     <= ST_ERROR;
          end else if (i_wire_renderer_state[7:0] == RSTATE_DONE) begin
            r_rend_rstn <= 1'b0;
            r_done      <= 1'b1;
            r_count     <= r_count + 32'd1;
            r_state     <= ST_RETIRE;
          end else if (w_timeout_hit) begin
            r_rend_rstn <= 1'b0;
            r_error     <= 1'b1;
            r_timeout   <= 1'b1;
            r_state     <= ST_ERROR;
          end else begin
            r_timer <= r_timer + 32'd1;
          end
        end
        ST_RETIRE: begin
          r_rend_rstn <= 1'b0;
          r_state     <= ST_IDLE;
        end
        ST_ERROR: begin
          r_rend_rstn <= 1'b0;
          if (i_wire_error_clear) begin
            r_error   <= 1'b0;
            r_timeout <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_painterengine_gpu_render_scheduler.sv
// Bench for the render scheduler: directed jobs, a renderer behaviour model,
// and a done-pulse monitor that pops expected jobs from a queue.
module tb_painterengine_gpu_render_scheduler;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_src, cmd_dst, cmd_sw, cmd_dw, cmd_x, cmd_y;
  logic        error_clear;
  logic        rend_rstn;
  logic [31:0] cfg_src, cfg_dst, cfg_sw, cfg_dw, cfg_x, cfg_y;
  logic [31:0] rend_state;
  logic        done_pulse;
  logic        err;
  logic        tmo;
  logic        busy;
  logic [7:0]  level;
  logic [31:0] count;
  logic [31:0] state;

  painterengine_gpu_render_scheduler #(
    .QUEUE_DEPTH    (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .i_wire_clock                      (clk),
    .i_wire_resetn                     (rst_n),
    .i_wire_cmd_valid                  (cmd_valid),
    .o_wire_cmd_ready                  (cmd_ready),
    .i_wire_cmd_src_address            (cmd_src),
    .i_wire_cmd_dst_address            (cmd_dst),
    .i_wire_cmd_src_width              (cmd_sw),
    .i_wire_cmd_dst_width              (cmd_dw),
    .i_wire_cmd_xcount                 (cmd_x),
    .i_wire_cmd_ycount                 (cmd_y),
    .i_wire_error_clear                (error_clear),
    .o_wire_renderer_resetn            (rend_rstn),
    .o_wire_src_frame_buffer_address   (cfg_src),
    .o_wire_dst_frame_buffer_address   (cfg_dst),
    .o_wire_src_frame_buffer_width     (cfg_sw),
    .o_wire_dst_frame_buffer_width     (cfg_dw),
    .o_wire_render_frame_buffer_xcount (cfg_x),
    .o_wire_render_frame_buffer_ycount (cfg_y),
    .i_wire_renderer_state             (rend_state),
    .o_wire_done_pulse                 (done_pulse),
    .o_wire_error                      (err),
    .o_wire_timeout                    (tmo),
    .o_wire_busy                       (busy),
    .o_wire_queue_level                (level),
    .o_wire_completed_count            (count),
    .o_wire_state                      (state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [191:0] exp_q[$];
  int n_done = 0;
  int n_rise = 0;
  logic [31:0] exp_count = 0;
  logic prev_rstn = 0;
  logic prev_done = 0;

  // Renderer model controls: 0 = DONE after rm_delay, 1 = ERROR after rm_delay, 2 = stuck
  int rm_mode  = 0;
  int rm_delay = 50;
  int rm_cnt   = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [191:0] mk_job(input logic [31:0] s, d, sw, dw, x, y);
    return {s, d, sw, dw, x, y};
  endfunction

  function automatic logic [191:0] cfg_word();
    return {cfg_src, cfg_dst, cfg_sw, cfg_dw, cfg_x, cfg_y};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_job(input logic [191:0] j, input bit retires);
    int waited = 0;
    @(negedge clk);
    {cmd_src, cmd_dst, cmd_sw, cmd_dw, cmd_x, cmd_y} = j;
    cmd_valid = 1'b1;
    while (!cmd_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("push_accept_ready", cmd_ready, 1'b1);
    if (retires) exp_q.push_back(j);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_state(input string name, input logic [7:0] s, input int budget);
    int w = 0;
    @(negedge clk);
    while (state[7:0] != s && w < budget) begin
      @(negedge clk);
      w++;
    end
    check(name, state, {24'd0, s});
  endtask

  task automatic wait_idle(input string name, input int budget);
    int w = 0;
    @(negedge clk);
    while (busy && w < budget) begin
      @(negedge clk);
      w++;
    end
    check(name, busy, 1'b0);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    error_clear = 1'b1;
    @(posedge clk);
    #1 error_clear = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, cmd_ready, 1'b0);
    check({tag, "_rend_rstn"}, rend_rstn, 1'b0);
    check({tag, "_cfg"}, cfg_word(), 192'd0);
    check({tag, "_flags"}, {done_pulse, err, tmo, busy}, 4'd0);
    check({tag, "_level"}, level, 8'd0);
    check({tag, "_count"}, count, 32'd0);
    check({tag, "_state"}, state, 32'd0);
  endtask

  // ---------------- renderer model ----------------
  initial begin
    rend_state = 32'd0;
    forever begin
      @(negedge clk);
      if (!rend_rstn) begin
        rm_cnt = 0;
        rend_state = 32'd0;
      end else begin
        rm_cnt++;
        if (rm_mode == 0 && rm_cnt >= rm_delay)      rend_state = 32'h0000_0005;
        else if (rm_mode == 1 && rm_cnt >= rm_delay) rend_state = 32'h0000_0006;
        else                                         rend_state = 32'h0000_0002;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [191:0] job_exp;
    if (!rst_n) begin
      exp_count = 0;
      prev_rstn = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (rend_rstn && !prev_rstn) n_rise++;
      if (done_pulse) begin
        n_done++;
        check("done_single_cycle", prev_done, 1'b0);
        if (exp_q.size() != 0) job_exp = exp_q.pop_front();
        else job_exp = '1;
        check("done_cfg", cfg_word(), job_exp);
        exp_count = exp_count + 32'd1;
        check("done_count", count, exp_count);
        check("done_rend_rstn_low", rend_rstn, 1'b0);
      end
      prev_rstn = rend_rstn;
      prev_done = done_pulse;
    end
  end

  // ---------------- directed tests ----------------
  initial begin
    logic [191:0] job1;
    int rise_before, done_before, run_cycles;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    {cmd_src, cmd_dst, cmd_sw, cmd_dw, cmd_x, cmd_y} = '0;
    error_clear = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    #1 check("ready_before_first_edge", cmd_ready, 1'b0);
    @(negedge clk);
    check("ready_after_release", cmd_ready, 1'b1);

    // Test 1: single job, DONE after 50 cycles, 3-cycle start latency
    rm_mode = 0; rm_delay = 50;
    job1 = mk_job(32'h1000, 32'h8000, 32'd64, 32'd64, 32'd16, 32'd4);
    push_job(job1, 1);
    repeat (3) @(negedge clk);
    check("t1_rstn_low_before_start", rend_rstn, 1'b0);
    @(negedge clk);
    check("t1_rstn_high_3_cycles", rend_rstn, 1'b1);
    check("t1_cfg_at_start", cfg_word(), job1);
    wait_idle("t1_idle", 300);
    check("t1_count", count, 32'd1);
    check("t1_done_pulses", n_done, 1);
    check("t1_cfg_held_after", cfg_word(), job1);

    // Test 3: zero-width job retires without releasing the renderer
    rise_before = n_rise;
    push_job(mk_job(32'h3000, 32'h9000, 32'd32, 32'd32, 32'd0, 32'd8), 1);
    wait_idle("t3_idle", 50);
    check("t3_no_renderer_start", n_rise, rise_before);
    check("t3_done_pulses", n_done, 2);
    check("t3_count", count, 32'd2);

    // Test 2: queue fills to 4 behind an active job, the 5th waits for the pop
    rm_delay = 40;
    push_job(mk_job(32'h2000, 32'hA000, 32'd8, 32'd8, 32'd8, 32'd8), 1);
    wait_state("t2_first_run", 8'h03, 20);
    for (int i = 1; i <= 4; i++)
      push_job(mk_job(32'h2000 + 32'(i) * 32'h100, 32'hA000 + 32'(i) * 32'h100,
                      32'd8, 32'd8, 32'(i) + 32'd1, 32'd2), 1);
    @(negedge clk);
    check("t2_level_full", level, 8'd4);
    check("t2_ready_low_full", cmd_ready, 1'b0);
    check("t2_busy_full", busy, 1'b1);
    push_job(mk_job(32'h2500, 32'hA500, 32'd8, 32'd8, 32'd6, 32'd2), 1);
    check("t2_fifth_after_first_retire", count, 32'd3);
    wait_idle("t2_idle", 1500);
    check("t2_count", count, 32'd8);
    check("t2_level_empty", level, 8'd0);

    // Test 4: renderer error with two jobs queued, clear flushes the queue
    rm_mode = 1; rm_delay = 20;
    push_job(mk_job(32'h4000, 32'hB000, 32'd16, 32'd16, 32'd4, 32'd4), 0);
    wait_state("t4_run", 8'h03, 20);
    push_job(mk_job(32'h4100, 32'hB100, 32'd16, 32'd16, 32'd4, 32'd4), 0);
    push_job(mk_job(32'h4200, 32'hB200, 32'd16, 32'd16, 32'd4, 32'd4), 0);
    wait_state("t4_error_state", 8'h05, 100);
    check("t4_error_flag", err, 1'b1);
    check("t4_timeout_flag", tmo, 1'b0);
    check("t4_level_held", level, 8'd2);
    check("t4_rend_rstn_low", rend_rstn, 1'b0);
    check("t4_ready_not_full", cmd_ready, 1'b1);
    pulse_clear();
    @(negedge clk);
    check("t4_level_flushed", level, 8'd0);
    check("t4_state_idle", state, 32'd0);
    check("t4_error_cleared", err, 1'b0);
    check("t4_busy_clear", busy, 1'b0);
    check("t4_count_unchanged", count, 32'd8);

    // Test 5: stuck renderer times out after exactly 100 RUN cycles
    rm_mode = 2;
    push_job(mk_job(32'h5000, 32'hC000, 32'd4, 32'd4, 32'd2, 32'd2), 0);
    wait_state("t5_run", 8'h03, 20);
    run_cycles = 0;
    while (state[7:0] == 8'h03 && run_cycles < 1000) begin
      run_cycles++;
      @(negedge clk);
    end
    check("t5_run_cycles", run_cycles, 100);
    check("t5_error_state", state, 32'd5);
    check("t5_timeout_flag", tmo, 1'b1);
    check("t5_error_flag", err, 1'b1);
    pulse_clear();
    @(negedge clk);
    check("t5_timeout_cleared", tmo, 1'b0);
    check("t5_state_idle", state, 32'd0);

    // Test 6: reset during RUN with three queued jobs
    push_job(mk_job(32'h6000, 32'hD000, 32'd4, 32'd4, 32'd2, 32'd2), 0);
    wait_state("t6_run", 8'h03, 20);
    for (int i = 0; i < 3; i++)
      push_job(mk_job(32'h6100 + 32'(i), 32'hD100, 32'd4, 32'd4, 32'd2, 32'd2), 0);
    @(negedge clk);
    check("t6_level_before", level, 8'd3);
    check("t6_rstn_running", rend_rstn, 1'b1);
    done_before = n_done;
    rst_n = 1'b0;
    #1 check_reset_vals("t6_in_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_no_done_pulse", n_done, done_before);
    check("t6_level_after", level, 8'd0);
    check("t6_state_after", state, 32'd0);
    check("t6_ready_after", cmd_ready, 1'b1);
    check("t6_count_after", count, 32'd0);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
